// File: rtl/vsq_pkg.sv
// vsq_pkg: shared VSQ constants and the buffer FSM state encoding
package vsq_pkg;
  localparam int VSQ_DATA_W = 18;
  localparam int VSQ_LANES  = 16;
  localparam int VSQ_DEPTH  = 64;
  localparam int VSQ_ADDR_W = 6;
  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_START = 2'd1,
    S_DRAIN = 2'd2,
    S_PAD   = 2'd3
  } vsq_state_e;
endpackage

// File: rtl/vsq_regfile.sv
// vsq_regfile: DEPTH x WIDTH flop storage, one sync write port, one async read port, no reset
//   clk                clock
//   we, waddr, wdata   synchronous write port
//   raddr -> rdata     combinational read port
module vsq_regfile #(
  parameter int WIDTH  = 288,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/vsq_buffer.sv
// vsq_buffer: collects DEPTH row vectors, mirrors accepted rows, pulses o_start, then holds rows for readout
//   i_clk, i_rst_n       clock, async active-low reset
//   i_valid/o_ready      upstream row handshake, i_data is the row
//   o_data               accepted row this cycle, zero otherwise
//   o_start              one-cycle pulse when a block is complete
//   i_buf_addr           quantizer read address, o_buf_data combinational row
//   i_flush              only with VSQ_BUF_ZERO_PAD_EN: zero-pad and close a partial block
module vsq_buffer import vsq_pkg::*; #(
  parameter int DATA_W = VSQ_DATA_W,
  parameter int LANES  = VSQ_LANES,
  parameter int DEPTH  = VSQ_DEPTH,
  parameter int ADDR_W = VSQ_ADDR_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_W*LANES-1:0] i_data,
  output logic [DATA_W*LANES-1:0] o_data,
  output logic                    o_start,
  input  logic [ADDR_W-1:0]       i_buf_addr,
  output logic [DATA_W*LANES-1:0] o_buf_data
`ifdef VSQ_BUF_ZERO_PAD_EN
  ,
  input  logic                    i_flush
`endif
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  vsq_state_e state;
  logic [ADDR_W-1:0] wr_ptr, drain_cnt;
  logic accept, we;
  logic [DATA_W*LANES-1:0] row;
  assign accept = i_valid && o_ready;
  // pad writes reuse the same path: no accept in S_PAD, so row is zero there
  assign row    = accept ? i_data : '0;
  assign we     = accept || state == S_PAD;
  assign o_data = row;
  vsq_regfile #(.WIDTH(DATA_W*LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_regfile (
    .clk  (i_clk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(row),
    .raddr(i_buf_addr),
    .rdata(o_buf_data)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state     <= S_FILL;
      wr_ptr    <= '0;
      drain_cnt <= '0;
      o_ready   <= 1'b1;
      o_start   <= 1'b0;
    end else begin
      o_start <= 1'b0;
      if (we) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        S_FILL:
          if (accept && wr_ptr == LAST) begin
            state   <= S_START;
            o_start <= 1'b1;
            o_ready <= 1'b0;
          end
`ifdef VSQ_BUF_ZERO_PAD_EN
          else if (i_flush && (accept || wr_ptr != '0)) begin
            state   <= S_PAD;
            o_ready <= 1'b0;
          end
`endif
        S_START: begin
          state     <= S_DRAIN;
          drain_cnt <= '0;
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == LAST) begin
            state   <= S_FILL;
            o_ready <= 1'b1;
          end
        end
        S_PAD:
          if (wr_ptr == LAST) begin
            state   <= S_START;
            o_start <= 1'b1;
          end
        default: state <= S_FILL;
      endcase
    end
endmodule

// File: tb/tb_vsq_buffer.sv
// tb_vsq_buffer: directed self-checking bench for vsq_buffer
module tb_vsq_buffer;
  import vsq_pkg::*;
  localparam int W = VSQ_DATA_W * VSQ_LANES;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic ready, start, v;
  logic [W-1:0] data = '0;
  logic [W-1:0] mirror, buf_data;
  logic [VSQ_ADDR_W-1:0] addr = '0;
`ifdef VSQ_BUF_ZERO_PAD_EN
  logic flush = 1'b0;
`endif
  int checks = 0;
  int failures = 0;
  int low, starts, first, acc, last_acc, nz;
  always #5 clk = ~clk;
  vsq_buffer dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (valid),
    .o_ready   (ready),
    .i_data    (data),
    .o_data    (mirror),
    .o_start   (start),
    .i_buf_addr(addr),
    .o_buf_data(buf_data)
`ifdef VSQ_BUF_ZERO_PAD_EN
    ,
    .i_flush   (flush)
`endif
  );
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] row_of(input int r);
    logic [W-1:0] val;
    int x;
    val = '0;
    for (int k = 0; k < VSQ_LANES; k++) begin
      x = r * VSQ_LANES + k;
      val[k*VSQ_DATA_W +: VSQ_DATA_W] = (k % 2 == 1) ? VSQ_DATA_W'(-x) : VSQ_DATA_W'(x);
    end
    return val;
  endfunction
  task automatic cyc(input logic vv, input logic [W-1:0] d, input int a);
    @(negedge clk);
    valid = vv;
    data  = d;
    addr  = VSQ_ADDR_W'(a);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", W'(ready), W'(1));
    check("rst_start", W'(start), W'(0));
    check("rst_data", mirror, '0);
    @(negedge clk);
    rst_n = 1'b1;
    // test 1: 64 back-to-back rows, then start pulse, readout, ready-low window
    for (int r = 0; r < 64; r++) begin
      cyc(1'b1, row_of(r), 0);
      check("t1_ready", W'(ready), W'(1));
      check("t1_mirror", mirror, row_of(r));
    end
    low = 0; starts = 0; first = -1;
    for (int c = 1; c <= 66; c++) begin
      cyc(1'b0, '0, c - 2);
      if (start) begin
        starts++;
        if (first < 0) first = c;
      end
      if (!ready) low++;
      if (c >= 2 && c <= 65) check("t1_read", buf_data, row_of(c - 2));
    end
    check("t1_start_cnt", W'(starts), W'(1));
    check("t1_start_cyc", W'(first), W'(1));
    check("t1_low_cycles", W'(low), W'(65));
    check("t1_ready_back", W'(ready), W'(1));
    // test 2: i_valid held high through the drain
    for (int r = 0; r < 64; r++) cyc(1'b1, row_of(64 + r), 0);
    for (int c = 1; c <= 66; c++) begin
      cyc(1'b1, row_of(128), (c >= 2 && c <= 65) ? c - 2 : 0);
      if (c <= 65) begin
        check("t2_ready_low", W'(ready), W'(0));
        check("t2_mirror_zero", mirror, '0);
      end
      if (c >= 2 && c <= 65) check("t2_read", buf_data, row_of(64 + c - 2));
      if (c == 66) begin
        check("t2_ready_high", W'(ready), W'(1));
        check("t2_mirror_row64", mirror, row_of(128));
        check("t2_old_addr0", buf_data, row_of(64));
      end
    end
    cyc(1'b0, '0, 0);
    check("t2_new_addr0", buf_data, row_of(128));
    cyc(1'b0, '0, 1);
    check("t2_old_addr1", buf_data, row_of(65));
    // test 4: complete the block, reset at drain_cnt=30
    for (int r = 1; r < 64; r++) cyc(1'b1, row_of(128 + r), 0);
    for (int c = 1; c <= 32; c++) begin
      cyc(1'b0, '0, 0);
      if (c == 1) check("t4_start", W'(start), W'(1));
    end
    check("t4_ready_pre", W'(ready), W'(0));
    rst_n = 1'b0;
    #1;
    check("t4_rst_ready", W'(ready), W'(1));
    check("t4_rst_start", W'(start), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    // test 3: bubbly input after the reset, single o_start after the 64th accept
    acc = 0; starts = 0; first = -1; last_acc = -1;
    for (int n = 0; n < 140; n++) begin
      v = (n % 2 == 0) && acc < 64;
      cyc(v, row_of(200 + n), n >= 128 ? n - 128 : 0);
      check("t3_mirror", mirror, v ? row_of(200 + n) : '0);
      if (v) begin
        check("t3_ready", W'(ready), W'(1));
        acc++;
        last_acc = n;
      end
      if (start) begin
        starts++;
        first = n;
      end
      if (n >= 128) check("t3_read", buf_data, row_of(200 + 2 * (n - 128)));
    end
    check("t3_start_cnt", W'(starts), W'(1));
    check("t3_start_cyc", W'(first), W'(last_acc + 1));
    repeat (60) cyc(1'b0, '0, 0);
    check("t3_ready_back", W'(ready), W'(1));
`ifdef VSQ_BUF_ZERO_PAD_EN
    // test 6: flush with wr_ptr=0 and no accept is ignored
    cyc(1'b0, '0, 0);
    flush = 1'b1;
    starts = 0; low = 0;
    for (int c = 1; c <= 70; c++) begin
      cyc(1'b0, '0, 0);
      flush = 1'b0;
      if (start) starts++;
      if (!ready) low++;
    end
    check("t6_no_start", W'(starts), W'(0));
    check("t6_ready_stays", W'(low), W'(0));
    // test 5: 10 rows then flush -> 54 pad cycles, start, zero-padded readout
    for (int r = 0; r < 10; r++) cyc(1'b1, row_of(400 + r), 0);
    cyc(1'b0, '0, 0);
    flush = 1'b1;
    starts = 0; low = 0; first = -1; nz = 0;
    for (int c = 1; c <= 119; c++) begin
      cyc(1'b0, '0, c >= 56 ? c - 56 : 0);
      flush = 1'b0;
      if (c <= 55 && !ready) low++;
      if (mirror != '0) nz++;
      if (start) begin
        starts++;
        first = c;
      end
      if (c >= 56) check("t5_read", buf_data, (c - 56) < 10 ? row_of(400 + c - 56) : '0);
    end
    check("t5_low_cycles", W'(low), W'(55));
    check("t5_start_cnt", W'(starts), W'(1));
    check("t5_start_cyc", W'(first), W'(55));
    check("t5_mirror_zero", W'(nz), W'(0));
    repeat (5) cyc(1'b0, '0, 0);
    check("t5_ready_back", W'(ready), W'(1));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
